rpn_frame_loader: RTL and testbench

Byte-stream front end for the programmable RPN calculator controller. It receives a length-prefixed program frame over a valid/ready byte interface and assembles 16-bit words. It writes those words into the controller's program memory through the controller's `wr`/`addr`/`datain` port, pulses `start`, and waits for the run to finish. It then returns the controller's `out` value, with a status code, over a result handshake.

---
 rtl/rpn_frame_loader.sv | 196 +++++++++++++++++++
 tb/tb_rpn_frame_loader.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_frame_loader.sv
// Byte-stream front end for the RPN calculator controller: takes a length-prefixed
// frame of little-endian 16-bit words, writes them into program memory, starts a
// run, waits for completion (or a timeout) and hands back the result with a status.
module rpn_frame_loader #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] res_data,
  output logic [1:0]  res_err,
  output logic        res_valid,
  input  logic        res_ack,
  output logic        c_wr,
  output logic [9:0]  c_addr,
  output logic [15:0] c_datain,
  output logic        c_start,
  input  logic        c_ready,
  input  logic [15:0] c_out
);

  localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  localparam logic [1:0] ErrOk      = 2'd0;
  localparam logic [1:0] ErrBadLen  = 2'd1;
  localparam logic [1:0] ErrTimeout = 2'd2;

  typedef enum logic [2:0] {
    StLen,
    StLoad,
    StStart,
    StWaitB,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic              phase_q, phase_d;  // 0: expecting low byte, 1: expecting high byte
  logic [7:0]        lo_q, lo_d;
  logic [10:0]       len_q, len_d;
  logic [10:0]       idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [9:0]        addr_q, addr_d;
  logic [15:0]       datain_q, datain_d;
  logic              start_q, start_d;
  logic              rvalid_q, rvalid_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [1:0]        rerr_q, rerr_d;

  logic              accept;
  logic [15:0]       word;

  // Bytes are only taken while the controller is idle; held low during reset.
  assign in_ready = nrst & c_ready & ((state_q == StLen) | (state_q == StLoad));
  assign accept   = in_valid & in_ready;
  assign word     = {in_data, lo_q};

  assign c_wr      = wr_q;
  assign c_addr    = addr_q;
  assign c_datain  = datain_q;
  assign c_start   = start_q;
  assign res_valid = rvalid_q;
  assign res_data  = rdata_q;
  assign res_err   = rerr_q;

  // Next-state and registered-output logic for the frame/run sequencer.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    lo_d     = lo_q;
    len_d    = len_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    wr_d     = 1'b0;
    addr_d   = addr_q;
    datain_d = datain_q;
    start_d  = 1'b0;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;

    case (state_q)
      StLen: begin
        if (accept) begin
          if (!phase_q) begin
            lo_d    = in_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if ((word == 16'd0) || (word > 16'd1024)) begin
              rerr_d   = ErrBadLen;
              rdata_d  = 16'd0;
              rvalid_d = 1'b1;
              state_d  = StDone;
            end else begin
              len_d   = word[10:0];
              idx_d   = 11'd0;
              state_d = StLoad;
            end
          end
        end
      end
      StLoad: begin
        if (accept) begin
          if (!phase_q) begin
            lo_d    = in_data;
            phase_d = 1'b1;
          end else begin
            phase_d  = 1'b0;
            wr_d     = 1'b1;
            addr_d   = idx_q[9:0];
            datain_d = word;
            idx_d    = idx_q + 11'd1;
            if (idx_q == len_q - 11'd1) begin
              state_d = StStart;
            end
          end
        end
      end
      StStart: begin
        // The last write is on the bus this cycle; the start pulse follows it.
        start_d = 1'b1;
        state_d = StWaitB;
      end
      StWaitB: begin
        if (!c_ready) begin
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (c_ready) begin
          rdata_d  = c_out;
          rerr_d   = ErrOk;
          rvalid_d = 1'b1;
          state_d  = StDone;
        end else if (cnt_q == TimeoutCnt) begin
          rdata_d  = 16'd0;
          rerr_d   = ErrTimeout;
          rvalid_d = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (res_ack) begin
          rvalid_d = 1'b0;
          phase_d  = 1'b0;
          state_d  = StLen;
        end
      end
      default: begin
        state_d = StLen;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= StLen;
      phase_q  <= 1'b0;
      lo_q     <= 8'd0;
      len_q    <= 11'd0;
      idx_q    <= 11'd0;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= 10'd0;
      datain_q <= 16'd0;
      start_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 16'd0;
      rerr_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      lo_q     <= lo_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      datain_q <= datain_d;
      start_q  <= start_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

endmodule

// File: tb/tb_rpn_frame_loader.sv
// Self-checking bench for rpn_frame_loader: a small stack-machine stand-in for the
// controller, a write/start monitor, and a frame-level reference model.
module tb_rpn_frame_loader;

  localparam int unsigned TIMEOUT = 100;

  typedef logic [15:0] mem_t [1024];
  typedef logic [7:0] bq_t [$];
  typedef struct packed {logic [9:0] a; logic [15:0] d;} wr_t;

  logic        clk = 1'b0;
  logic        nrst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] res_data;
  logic [1:0]  res_err;
  logic        res_valid;
  logic        res_ack;
  logic        c_wr;
  logic [9:0]  c_addr;
  logic [15:0] c_datain;
  logic        c_start;
  logic        c_ready;
  logic [15:0] c_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mem_t pmem;
  wr_t  wr_q[$];
  int   start_cnt, clash_cnt, last_wr_cyc, start_cyc, fall_cyc, rise_cyc, rv_cyc;
  logic prev_ready = 1'b1;
  logic prev_rv = 1'b0;

  rpn_frame_loader #(.TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .res_data (res_data),
    .res_err  (res_err),
    .res_valid(res_valid),
    .res_ack  (res_ack),
    .c_wr     (c_wr),
    .c_addr   (c_addr),
    .c_datain (c_datain),
    .c_start  (c_start),
    .c_ready  (c_ready),
    .c_out    (c_out)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stack machine: bit15=0 push imm15, 8002 add, 8003 mul, 8007 jump 0, C000 halt.
  function automatic void interp(input mem_t m, output logic [15:0] res, output bit hang);
    logic [15:0] st[$];
    logic [15:0] a, b, w;
    int pc;
    pc = 0;
    res = 16'h0;
    hang = 1'b1;
    for (int s = 0; s < 3000; s++) begin
      w = m[pc];
      if (w[15] === 1'b0) begin
        st.push_back({1'b0, w[14:0]});
        pc++;
      end else if (w === 16'hC000) begin
        if (st.size() > 0) res = st[$];
        hang = 1'b0;
        return;
      end else if ((w === 16'h8002 || w === 16'h8003) && st.size() >= 2) begin
        b = st.pop_back();
        a = st.pop_back();
        st.push_back((w === 16'h8002) ? a + b : a * b);
        pc++;
      end else if (w === 16'h8007) begin
        pc = 0;
      end else begin
        pc++;
      end
      if (pc > 1023) return;
    end
  endfunction

  // Monitor of the controller-side bus, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (c_wr) begin
      wr_q.push_back({c_addr, c_datain});
      pmem[c_addr] = c_datain;
      last_wr_cyc = cyc;
    end
    if (c_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (c_wr && c_start) clash_cnt++;
    if (prev_ready && !c_ready) fall_cyc = cyc;
    if (!prev_ready && c_ready) rise_cyc = cyc;
    if (res_valid && !prev_rv) rv_cyc = cyc;
    prev_ready = c_ready;
    prev_rv = res_valid;
  end

  // Controller stand-in: goes busy the cycle after start, runs the program from pmem.
  initial begin : ctrl_stub
    logic [15:0] r;
    bit h;
    int lat;
    c_ready = 1'b1;
    c_out = 16'h0;
    forever begin
      @(negedge clk);
      if (c_start === 1'b1) begin
        interp(pmem, r, h);
        @(posedge clk);
        #1 c_ready = 1'b0;
        lat = $urandom_range(1, 6);
        forever begin
          @(negedge clk);
          if (!nrst) break;
          if (!h) begin
            lat--;
            if (lat == 0) break;
          end
        end
        if (nrst) begin
          @(posedge clk);
          #1;
        end
        c_out = h ? 16'h0 : r;
        c_ready = 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int acc);
    int n;
    n = 0;
    in_data = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      n++;
      if (n > 500) begin
        check_eq("byte accept bound", 0, 1);
        in_valid = 1'b0;
        acc = cyc;
        return;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " in_ready"}, in_ready, 0);
    check_eq({tag, " c_wr"}, c_wr, 0);
    check_eq({tag, " c_start"}, c_start, 0);
    check_eq({tag, " c_addr"}, c_addr, 0);
    check_eq({tag, " c_datain"}, c_datain, 0);
    check_eq({tag, " res_valid"}, res_valid, 0);
    check_eq({tag, " res_data"}, res_data, 0);
    check_eq({tag, " res_err"}, res_err, 0);
  endtask

  // Sends one frame, predicts writes/result from the frame bytes alone, and checks.
  task automatic run_frame(input bq_t fb, input bit gaps, input int hold, input string tag);
    int n, acc, first_acc, exp_err;
    logic [15:0] exp_data, r;
    bit bad, h, got;
    mem_t rm;
    wr_t e;
    n = int'({fb[1], fb[0]});
    bad = (n == 0) || (n > 1024);
    for (int i = 0; i < 1024; i++) rm[i] = 16'h0;
    if (!bad) for (int i = 0; i < n; i++) rm[i] = {fb[2*i+3], fb[2*i+2]};
    if (bad) begin
      exp_err = 1;
      exp_data = 16'h0;
    end else begin
      interp(rm, r, h);
      exp_err = h ? 2 : 0;
      exp_data = h ? 16'h0 : r;
    end
    wr_q.delete();
    start_cnt = 0;
    clash_cnt = 0;
    first_acc = 0;
    acc = 0;
    for (int i = 0; i < fb.size(); i++) begin
      if (gaps) begin
        res_ack = 1'($urandom_range(0, 1));  // stray acks with no result pending
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      send_byte(fb[i], acc);
      if (i == 0) first_acc = acc;
    end
    res_ack = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 2000 && !got; w++) begin
      @(negedge clk);
      if (res_valid) got = 1'b1;
    end
    check_eq({tag, " result arrives"}, got, 1);
    if (!got) begin
      @(posedge clk);
      #1;
      return;
    end
    check_eq({tag, " res_data"}, res_data, exp_data);
    check_eq({tag, " res_err"}, res_err, exp_err);
    check_eq({tag, " in_ready in done"}, in_ready, 0);
    check_eq({tag, " start count"}, start_cnt, bad ? 0 : 1);
    check_eq({tag, " write count"}, wr_q.size(), bad ? 0 : n);
    check_eq({tag, " wr/start overlap"}, clash_cnt, 0);
    if (!bad) begin
      for (int i = 0; i < n && i < wr_q.size(); i++) begin
        e = wr_q[i];
        check_eq($sformatf("%s addr[%0d]", tag, i), e.a, i);
        check_eq($sformatf("%s data[%0d]", tag, i), e.d, rm[i]);
      end
      check_eq({tag, " last wr cycle"}, last_wr_cyc, acc + 1);
      check_eq({tag, " start cycle"}, start_cyc, acc + 2);
      if (exp_err == 2) check_eq({tag, " timeout latency"}, rv_cyc, fall_cyc + 1 + TIMEOUT + 1);
      else check_eq({tag, " done latency"}, rv_cyc, rise_cyc + 1);
    end else begin
      check_eq({tag, " bad-len latency"}, rv_cyc, acc + 1);
    end
    if (!gaps) check_eq({tag, " byte rate"}, acc - first_acc, fb.size() - 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq({tag, " hold valid"}, res_valid, 1);
      check_eq({tag, " hold data"}, res_data, exp_data);
      check_eq({tag, " hold err"}, res_err, exp_err);
      check_eq({tag, " hold in_ready"}, in_ready, 0);
    end
    @(posedge clk);
    #1 res_ack = 1'b1;
    @(posedge clk);
    #1 res_ack = 1'b0;
    @(negedge clk);
    check_eq({tag, " valid cleared"}, res_valid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t f, add_f, mul_f;
    int acc, k, n;
    nrst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    res_ack = 1'b0;
    add_f = '{8'h04, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h02, 8'h80, 8'h00, 8'hC0};
    mul_f = '{8'h04, 8'h00, 8'h07, 8'h00, 8'h06, 8'h00, 8'h03, 8'h80, 8'h00, 8'hC0};
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    nrst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle in_ready", in_ready, 1);

    run_frame(add_f, 1'b0, 0, "add");
    run_frame(mul_f, 1'b1, 0, "mul gaps");

    f = '{8'h00, 8'h00};
    run_frame(f, 1'b0, 0, "len0");
    f = '{8'h01, 8'h04};
    run_frame(f, 1'b1, 0, "len1025");

    run_frame(add_f, 1'b0, 5, "backpressure");
    run_frame(add_f, 1'b0, 0, "add again");

    f = '{8'h01, 8'h00, 8'h00, 8'hC0};
    run_frame(f, 1'b0, 0, "len1");

    f.delete();
    f.push_back(8'h00);
    f.push_back(8'h04);
    for (int i = 0; i < 1023; i++) begin
      f.push_back(8'(i % 3));
      f.push_back(8'h00);
    end
    f.push_back(8'h00);
    f.push_back(8'hC0);
    run_frame(f, 1'b0, 0, "len1024");

    for (int t = 0; t < 10; t++) begin
      f.delete();
      if ($urandom_range(0, 4) == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1025, 65535);
        f.push_back(8'(n));
        f.push_back(8'(n >> 8));
      end else begin
        k = $urandom_range(2, 5);
        n = 2 * k;
        f.push_back(8'(n));
        f.push_back(8'h00);
        for (int i = 0; i < k; i++) begin
          f.push_back(8'($urandom_range(0, 40)));
          f.push_back(8'h00);
        end
        for (int i = 0; i < k - 1; i++) begin
          f.push_back(($urandom_range(0, 1) == 0) ? 8'h02 : 8'h03);
          f.push_back(8'h80);
        end
        f.push_back(8'h00);
        f.push_back(8'hC0);
      end
      run_frame(f, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $sformatf("rand%0d", t));
    end

    // Reset in the middle of a program load.
    start_cnt = 0;
    send_byte(8'h04, acc);
    send_byte(8'h00, acc);
    send_byte(8'h02, acc);
    send_byte(8'h00, acc);
    send_byte(8'h03, acc);
    check_eq("pre-reset datain", c_datain, 16'h0002);
    nrst = 1'b0;
    #1;
    check_reset_outputs("mid-load reset");
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("mid-load no start", start_cnt, 0);
    run_frame(add_f, 1'b0, 0, "after reset");

    // Hung program: push 0, jump 0.
    f = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h07, 8'h80};
    run_frame(f, 1'b0, 0, "timeout");
    in_data = 8'h55;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("post-timeout in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post-reset in_ready", in_ready, 1);
    run_frame(add_f, 1'b1, 0, "final add");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
